// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for pipe_stage_skid: upstream accept side and
// downstream present side of one pipeline stage.
interface pipe_stage_skid_if #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 160
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  // Stage side: consumes the upstream entry, produces the downstream entry.
  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

  // Environment side: drives the stage and absorbs its output.
  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Fully handshaked pipeline stage register with a 2-entry skid buffer.
// in_ready comes straight from the skid valid flop, so backpressure never
// forms a combinational path from out_ready. Bubbles present a zero
// control field; payload is held. Includes synchronous flush and a
// saturating stall-cycle counter.
module pipe_stage_skid #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 160,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  pipe_stage_skid_if.slave  bus,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              m_valid_r, m_valid_s;
  logic [CTRL_W-1:0] m_ctrl_r,  m_ctrl_s;
  logic [DATA_W-1:0] m_data_r,  m_data_s;
  logic              s_valid_r, s_valid_s;
  logic [CTRL_W-1:0] s_ctrl_r,  s_ctrl_s;
  logic [DATA_W-1:0] s_data_r,  s_data_s;
  logic [CNT_W-1:0]  stall_cnt_r, stall_cnt_s;
  logic              in_fire_s;
  logic              out_fire_s;

  assign in_fire_s  = bus.in_valid & ~s_valid_r;
  assign out_fire_s = m_valid_r & bus.out_ready;

  // Next-state for main/skid entries: flush first, then drain/refill of main, else fill skid.
  always_comb begin
    m_valid_s = m_valid_r;
    m_ctrl_s  = m_ctrl_r;
    m_data_s  = m_data_r;
    s_valid_s = s_valid_r;
    s_ctrl_s  = s_ctrl_r;
    s_data_s  = s_data_r;
    if (flush) begin
      m_valid_s = 1'b0;
      s_valid_s = 1'b0;
      m_ctrl_s  = {CTRL_W{1'b0}};
      s_ctrl_s  = {CTRL_W{1'b0}};
    end else if (!m_valid_r || out_fire_s) begin
      // Main is empty or leaving: refill from skid first to keep FIFO order.
      if (s_valid_r) begin
        m_valid_s = 1'b1;
        m_ctrl_s  = s_ctrl_r;
        m_data_s  = s_data_r;
        s_valid_s = 1'b0;
      end else if (in_fire_s) begin
        m_valid_s = 1'b1;
        m_ctrl_s  = bus.in_ctrl;
        m_data_s  = bus.in_data;
      end else begin
        m_valid_s = 1'b0;
      end
    end else begin
      // Main is stalled: an accepted entry overflows into skid.
      if (in_fire_s) begin
        s_valid_s = 1'b1;
        s_ctrl_s  = bus.in_ctrl;
        s_data_s  = bus.in_data;
      end else begin
        s_valid_s = s_valid_r;
      end
    end
  end

  // Next-state for the stall counter: count stalled cycles, saturate, ignore flush cycles.
  always_comb begin
    stall_cnt_s = stall_cnt_r;
    if (m_valid_r && !bus.out_ready && !flush && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_s = stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_s = stall_cnt_r;
    end
  end

  // State registers with asynchronous clear of every entry field and the counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid_r   <= 1'b0;
      m_ctrl_r    <= {CTRL_W{1'b0}};
      m_data_r    <= {DATA_W{1'b0}};
      s_valid_r   <= 1'b0;
      s_ctrl_r    <= {CTRL_W{1'b0}};
      s_data_r    <= {DATA_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      m_valid_r   <= m_valid_s;
      m_ctrl_r    <= m_ctrl_s;
      m_data_r    <= m_data_s;
      s_valid_r   <= s_valid_s;
      s_ctrl_r    <= s_ctrl_s;
      s_data_r    <= s_data_s;
      stall_cnt_r <= stall_cnt_s;
    end
  end

  // Outputs come only from flops; control is masked so a bubble carries no write enables.
  assign bus.in_ready  = ~s_valid_r;
  assign bus.out_valid = m_valid_r;
  assign bus.out_ctrl  = m_ctrl_r & {CTRL_W{m_valid_r}};
  assign bus.out_data  = m_data_r;
  assign occupancy     = {1'b0, m_valid_r} + {1'b0, s_valid_r};
  assign stall_cnt     = stall_cnt_r;

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, fully handshaked pipeline stage register, successor to the fixed-field ID/EX register.
- Carries a generic control field (CTRL_W bits, zeroed on bubbles) and a data payload (DATA_W bits) between any two pipeline stages.
- A 2-entry skid buffer decouples in_ready from out_ready, so backpressure needs no combinational path.
- Adds synchronous flush and a saturating stall-cycle performance counter.

Parameters:
- CTRL_W, 16: control-bit width (RegWrite, MemWrite, ALUOp, ...); forced to 0 on a bubble.
- DATA_W, 160: payload width (operands, PC, immediate, register indices); held, never cleared except at reset.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  control field; 0 whenever out_valid=0.
- out_data  out  DATA_W  payload of the presented entry.
- occupancy  out  2  entries held (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturates.

Behaviour:
- Storage:
  - main entry (m_valid, m_ctrl, m_data) drives the outputs.
  - skid entry (s_valid, s_ctrl, s_data) holds overflow.
- Reset (reset=0, asynchronous): m_valid=s_valid=0, all ctrl/data regs=0, stall_cnt=0.
  - Resulting outputs: out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0.
- in_ready = !s_valid. It is registered state only, with no combinational path from out_ready.
- Accept: in_fire = in_valid & in_ready.
- Emit: out_fire = m_valid & out_ready.
- Latency: an entry accepted at edge N appears on the outputs after edge N (1 cycle) when main is empty or draining.
- Per rising edge, with flush=0:
  - Main empty, in_fire: entry loads into main.
  - Main full, out_fire, skid empty, in_fire: main loads the new entry.
  - Main full, out_fire, skid full: main loads skid and skid clears. in_fire cannot occur (in_ready=0).
  - Main full, no out_fire, in_fire: entry loads into skid, and in_ready=0 next cycle.
  - Main full, out_fire, no in_fire, skid empty: m_valid=0.
- Order is strictly FIFO. No entry is ever dropped or duplicated while flush=0.
- Flush (synchronous, highest priority):
  - At the edge: m_valid=s_valid=0, m_ctrl=s_ctrl=0.
  - An in_valid entry presented in the flush cycle is discarded.
  - An out_fire in the flush cycle still counts as delivered downstream.
  - Data regs are held.
  - in_ready=1 the next cycle.
- out_ctrl = m_valid ? m_ctrl : 0, so a bubble never carries write enables.
- out_data = m_data, held when invalid.
- occupancy = m_valid + s_valid.
- stall_cnt:
  - +1 on each edge where m_valid & !out_ready & !flush.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset; unaffected by flush.
- Invariant: s_valid=1 implies m_valid=1. The verifier asserts this and the FIFO ordering.
- in_ctrl/in_data are sampled only on in_fire. Values while in_valid=0 are don't-care.
- Reset asserted mid-transfer: state clears immediately (asynchronously), and outputs drop within the same cycle.

Test Plan:
- Streaming: out_ready=1, in_valid=1 for 8 cycles with data 1..8 -> out_data 1..8 on consecutive cycles, 1-cycle lag, occupancy=1, stall_cnt=0.
- Backpressure: send A,B while out_ready=0 -> occupancy=2, in_ready=0, stall_cnt increments each cycle. Release out_ready -> A then B emitted in order, and in_ready=1 one cycle after A leaves.
- Bubble gating: in_ctrl=16'hFFFF, then in_valid=0 -> after A drains, out_valid=0 and out_ctrl=0 while out_data still shows A's data.
- Flush while full (occupancy=2), in_valid=1 with C -> next cycle occupancy=0, out_ctrl=0, C never emitted, stall_cnt retains its value.
- Saturation: CNT_W=4, hold out_ready=0 for 20 cycles with a valid entry -> stall_cnt stops at 15.
- Async reset mid-stall: drop reset between edges -> out_valid, occupancy and stall_cnt go to 0 before the next edge, and in_ready=1.
